// File: rtl/posit_encoder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : posit_encoder_pipe                                           |
// | Description : Three-stage posit encoder (N=32, ES=3). Builds the regime    |
// |               run, right-shifts {exp,frac} behind it, then rounds to        |
// |               nearest-even with saturation and applies the sign.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module posit_encoder_pipe #(
   parameter int N  = 32,
   parameter int ES = 3,
   parameter int KW = 7,
   parameter int FW = N - ES - 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sign,
   input  logic                 in_zero,
   input  logic                 in_nar,
   input  logic signed [KW-1:0] in_k,
   input  logic [ES-1:0]        in_exp,
   input  logic [FW-1:0]        in_frac,
   input  logic                 in_sticky,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_posit
);

   // {exp,frac} width, zero padding that fills it to 2N, and regime-length width
   localparam int c_ew  = ES + FW;
   localparam int c_pad = 2 * N - c_ew;
   localparam int c_lw  = $clog2(N + 1);

   // Regime values outside [-(N-1), N-3] cannot be represented by the shifter
   localparam logic signed [KW-1:0] c_kmax = KW'(N - 2);
   localparam logic signed [KW-1:0] c_kmin = KW'(-(N - 1));

   // Whole pipe advances together: free when the output register is empty or draining
   logic w_adv;
   assign w_adv    = !out_valid | out_ready;
   assign in_ready = w_adv;

   // ------------------------------------------------------------------ stage 1
   logic              w_satmax;
   logic              w_satmin;
   logic              w_kpos;
   logic [KW-1:0]     w_kmag;
   logic [c_lw-1:0]   w_len;
   logic [N-1:0]      w_regime;

   logic              r1_valid;
   logic              r1_sign;
   logic              r1_zero;
   logic              r1_nar;
   logic              r1_satmax;
   logic              r1_satmin;
   logic              r1_sticky;
   logic [c_lw-1:0]   r1_len;
   logic [N-1:0]      r1_regime;
   logic [c_ew-1:0]   r1_ef;

   // Clamp k and build the left-aligned regime pattern and its length
   always_comb begin
      w_satmax = (in_k >= c_kmax);
      w_satmin = (in_k < c_kmin);
      w_kpos   = ~in_k[KW-1];
      w_kmag   = w_kpos ? in_k : -in_k;
      w_len    = '0;
      w_regime = '0;
      if (!w_satmax && !w_satmin) begin
         if (w_kpos) begin
            // k+1 ones then the terminating zero
            w_len    = c_lw'(w_kmag) + c_lw'(2);
            w_regime = ~({N{1'b1}} >> (w_kmag + 1'b1));
         end else begin
            // -k zeros then the terminating one
            w_len    = c_lw'(w_kmag) + c_lw'(1);
            w_regime = {1'b1, {(N-1){1'b0}}} >> w_kmag;
         end
      end
   end

   // Stage 1 register: flags, sign, regime pattern/length and raw {exp,frac}
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid  <= 1'b0;
         r1_sign   <= 1'b0;
         r1_zero   <= 1'b0;
         r1_nar    <= 1'b0;
         r1_satmax <= 1'b0;
         r1_satmin <= 1'b0;
         r1_sticky <= 1'b0;
         r1_len    <= '0;
         r1_regime <= '0;
         r1_ef     <= '0;
      end else if (w_adv) begin
         r1_valid  <= in_valid;
         r1_sign   <= in_sign;
         r1_zero   <= in_zero;
         r1_nar    <= in_nar;
         r1_satmax <= w_satmax;
         r1_satmin <= w_satmin;
         r1_sticky <= in_sticky;
         r1_len    <= w_len;
         r1_regime <= w_regime;
         r1_ef     <= {in_exp, in_frac};
      end
   end

   // ------------------------------------------------------------------ stage 2
   logic [2*N-1:0]    w_field;

   logic              r2_valid;
   logic              r2_sign;
   logic              r2_zero;
   logic              r2_nar;
   logic              r2_satmax;
   logic              r2_satmin;
   logic [N-2:0]      r2_mag;
   logic              r2_guard;
   logic              r2_sticky;

   // Regime in the top of a 2N field, {exp,frac} shifted right by the regime length
   always_comb begin
      w_field = {r1_regime, {N{1'b0}}} | ({r1_ef, {c_pad{1'b0}}} >> r1_len);
   end

   // Stage 2 register: N-1 bit magnitude, guard bit and accumulated sticky
   always_ff @(posedge clk) begin
      if (rst) begin
         r2_valid  <= 1'b0;
         r2_sign   <= 1'b0;
         r2_zero   <= 1'b0;
         r2_nar    <= 1'b0;
         r2_satmax <= 1'b0;
         r2_satmin <= 1'b0;
         r2_mag    <= '0;
         r2_guard  <= 1'b0;
         r2_sticky <= 1'b0;
      end else if (w_adv) begin
         r2_valid  <= r1_valid;
         r2_sign   <= r1_sign;
         r2_zero   <= r1_zero;
         r2_nar    <= r1_nar;
         r2_satmax <= r1_satmax;
         r2_satmin <= r1_satmin;
         r2_mag    <= w_field[2*N-1 -: N-1];
         r2_guard  <= w_field[N];
         r2_sticky <= (|w_field[N-1:0]) | r1_sticky;
      end
   end

   // ------------------------------------------------------------------ stage 3
   logic              w_inc;
   logic [N-2:0]      w_mag;
   logic [N-1:0]      w_word;

   // Round to nearest even, saturate, apply sign, then override with specials
   always_comb begin
      w_inc = r2_guard & (r2_mag[0] | r2_sticky);
      // Cannot carry out: the largest unsaturated magnitude has a zero LSB region
      w_mag = r2_mag + {{(N-2){1'b0}}, w_inc};
      if (r2_satmax) begin
         w_mag = {(N-1){1'b1}};
      end else if (r2_satmin || (w_mag == '0)) begin
         // A nonzero value never encodes as zero; clamp to minpos
         w_mag = {{(N-2){1'b0}}, 1'b1};
      end
      w_word = r2_sign ? (~{1'b0, w_mag} + N'(1)) : {1'b0, w_mag};
      if (r2_nar) begin
         w_word = {1'b1, {(N-1){1'b0}}};
      end else if (r2_zero) begin
         w_word = '0;
      end
   end

   // Output register; the word only changes when a real operand arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_posit <= '0;
      end else if (w_adv) begin
         out_valid <= r2_valid;
         if (r2_valid) begin
            out_posit <= w_word;
         end
      end
   end

endmodule
`default_nettype wire
